idex_hazard_stage: RTL and testbench

- ID/EX pipeline register for the 5-stage MIPS core, with integrated load-use hazard detection.
- Captures decoded operands, register specifiers and control bits from ID each cycle.
- Provides IDEX_Rs/IDEX_Rt to the downstream forwarding unit and registered operands/control to EX.
- On a load-use dependence it inserts a bubble and freezes PC and IF/ID. It also squashes on branch flush and keeps a saturating stall counter.

---
 rtl/idex_pkg.sv | 26 ++
 rtl/idex_hazard_stage_load_use_detect.sv | 17 +
 rtl/idex_hazard_stage.sv | 83 ++++++++
 tb/tb_idex_hazard_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/idex_pkg.sv
// Shared constants for the ID/EX stage: control-bundle layout and register-specifier width.
package idex_pkg;

    localparam int CTRL_W        = 8;
    localparam int CTRL_REGWRITE = 7;
    localparam int CTRL_MEMREAD  = 6;
    localparam int CTRL_MEMWRITE = 5;
    localparam int CTRL_MEMTOREG = 4;
    localparam int CTRL_ALUSRC   = 3;
    localparam int CTRL_REGDST   = 2;
    localparam int CTRL_ALUOP_HI = 1;
    localparam int CTRL_ALUOP_LO = 0;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    // True when a valid producer writing a real register feeds a reader's source specifier.
    function automatic logic regDepends(input logic [REG_W-1:0] producer,
                                        input logic [REG_W-1:0] src1,
                                        input logic [REG_W-1:0] src2,
                                        input logic             usesSrc2);
        return (producer != REG_ZERO) &&
               ((producer == src1) || (usesSrc2 && (producer == src2)));
    endfunction

endpackage

// File: rtl/idex_hazard_stage_load_use_detect.sv
// Combinational load-use detector: a load in EX whose destination is read by the instruction in ID.
module load_use_detect
    import idex_pkg::*;
(
    input  logic             exValid,
    input  logic             exMemRead,
    input  logic [REG_W-1:0] exRt,
    input  logic             idValid,
    input  logic [REG_W-1:0] idRs,
    input  logic [REG_W-1:0] idRt,
    input  logic             idUsesRt,
    output logic             hazard
);

    assign hazard = exValid & exMemRead & idValid & regDepends(exRt, idRs, idRt, idUsesRt);

endmodule

// File: rtl/idex_hazard_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch squash and a saturating stall counter.
module idex_hazard_stage
    import idex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_W-1:0]  ID_Rs,
    input  logic [REG_W-1:0]  ID_Rt,
    input  logic [REG_W-1:0]  ID_Rd,
    input  logic              ID_UsesRt,
    input  logic [DATA_W-1:0] ID_ReadA,
    input  logic [DATA_W-1:0] ID_ReadB,
    input  logic [DATA_W-1:0] ID_Imm,
    input  logic [CTRL_W-1:0] ID_Ctrl,
    input  logic              ID_Valid,
    input  logic              Flush,
    output logic [REG_W-1:0]  IDEX_Rs,
    output logic [REG_W-1:0]  IDEX_Rt,
    output logic [REG_W-1:0]  IDEX_Rd,
    output logic [DATA_W-1:0] IDEX_A,
    output logic [DATA_W-1:0] IDEX_B,
    output logic [DATA_W-1:0] IDEX_Imm,
    output logic [CTRL_W-1:0] IDEX_Ctrl,
    output logic              IDEX_Valid,
    output logic              PCWrite,
    output logic              IFID_Write,
    output logic [CNT_W-1:0]  StallCount
);

    logic hz;
    logic stallReq;

    load_use_detect uDetect (
        .exValid   (IDEX_Valid),
        .exMemRead (IDEX_Ctrl[CTRL_MEMREAD]),
        .exRt      (IDEX_Rt),
        .idValid   (ID_Valid),
        .idRs      (ID_Rs),
        .idRt      (ID_Rt),
        .idUsesRt  (ID_UsesRt),
        .hazard    (hz)
    );

    // A squashed ID instruction cannot be stalled on; reset keeps the front end running.
    assign stallReq   = hz & ~Flush;
    assign PCWrite    = rst | ~stallReq;
    assign IFID_Write = rst | ~stallReq;

    always_ff @(posedge clk) begin
        if (rst) begin
            IDEX_Rs    <= '0;
            IDEX_Rt    <= '0;
            IDEX_Rd    <= '0;
            IDEX_A     <= '0;
            IDEX_B     <= '0;
            IDEX_Imm   <= '0;
            IDEX_Ctrl  <= '0;
            IDEX_Valid <= 1'b0;
            StallCount <= '0;
        end else begin
            IDEX_Rs  <= ID_Rs;
            IDEX_Rt  <= ID_Rt;
            IDEX_Rd  <= ID_Rd;
            IDEX_A   <= ID_ReadA;
            IDEX_B   <= ID_ReadB;
            IDEX_Imm <= ID_Imm;
            if (Flush || hz) begin
                IDEX_Ctrl  <= '0;
                IDEX_Valid <= 1'b0;
            end else begin
                IDEX_Ctrl  <= ID_Valid ? ID_Ctrl : '0;
                IDEX_Valid <= ID_Valid;
            end
            if (stallReq && (StallCount != {CNT_W{1'b1}})) begin
                StallCount <= StallCount + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_idex_hazard_stage.sv
// Bench for idex_hazard_stage: directed vector table, saturation sequence, and randomized model check.
module tb_idex_hazard_stage;

    logic        clk;
    logic        rst;
    logic [4:0]  ID_Rs, ID_Rt, ID_Rd;
    logic        ID_UsesRt;
    logic [31:0] ID_ReadA, ID_ReadB, ID_Imm;
    logic [7:0]  ID_Ctrl;
    logic        ID_Valid, Flush;

    logic [4:0]  IDEX_Rs, IDEX_Rt, IDEX_Rd;
    logic [31:0] IDEX_A, IDEX_B, IDEX_Imm;
    logic [7:0]  IDEX_Ctrl;
    logic        IDEX_Valid, PCWrite, IFID_Write;
    logic [15:0] StallCount;

    logic [4:0]  sRs, sRt, sRd;
    logic [31:0] sA, sB, sImm;
    logic [7:0]  sCtrl;
    logic        sValid, sPCWrite, sIFID_Write;
    logic [1:0]  sStallCount;

    int vectors = 0;
    int miscompares = 0;

    // Reference state: what the EX slot should hold, kept as plain bench variables.
    logic [4:0]  mRs, mRt, mRd;
    logic [31:0] mA, mB, mImm;
    logic [7:0]  mCtrl;
    logic        mValid;
    int          mCnt, mCntSat;
    logic        mPcw;
    logic        seenPcw, seenIfid, seenSatPcw, seenSatIfid;

    idex_hazard_stage dut (
        .clk(clk), .rst(rst),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd), .ID_UsesRt(ID_UsesRt),
        .ID_ReadA(ID_ReadA), .ID_ReadB(ID_ReadB), .ID_Imm(ID_Imm),
        .ID_Ctrl(ID_Ctrl), .ID_Valid(ID_Valid), .Flush(Flush),
        .IDEX_Rs(IDEX_Rs), .IDEX_Rt(IDEX_Rt), .IDEX_Rd(IDEX_Rd),
        .IDEX_A(IDEX_A), .IDEX_B(IDEX_B), .IDEX_Imm(IDEX_Imm),
        .IDEX_Ctrl(IDEX_Ctrl), .IDEX_Valid(IDEX_Valid),
        .PCWrite(PCWrite), .IFID_Write(IFID_Write), .StallCount(StallCount)
    );

    idex_hazard_stage #(.DATA_W(32), .CNT_W(2)) dutSat (
        .clk(clk), .rst(rst),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd), .ID_UsesRt(ID_UsesRt),
        .ID_ReadA(ID_ReadA), .ID_ReadB(ID_ReadB), .ID_Imm(ID_Imm),
        .ID_Ctrl(ID_Ctrl), .ID_Valid(ID_Valid), .Flush(Flush),
        .IDEX_Rs(sRs), .IDEX_Rt(sRt), .IDEX_Rd(sRd),
        .IDEX_A(sA), .IDEX_B(sB), .IDEX_Imm(sImm),
        .IDEX_Ctrl(sCtrl), .IDEX_Valid(sValid),
        .PCWrite(sPCWrite), .IFID_Write(sIFID_Write), .StallCount(sStallCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic [4:0]  rs, rt, rd;
        logic        usesRt;
        logic [7:0]  ctrl;
        logic        valid, flush;
        logic [31:0] a;
        logic        expPcw, expValid;
        logic [7:0]  expCtrl;
        logic [4:0]  expRs;
        logic [31:0] expA;
        int          expCnt;
    } vec_t;

    vec_t table_q[$];

    function automatic vec_t mk(logic r, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                logic u, logic [7:0] c, logic v, logic f, logic [31:0] a,
                                logic ePcw, logic eV, logic [7:0] eC, logic [4:0] eRs,
                                logic [31:0] eA, int eCnt);
        vec_t t;
        t.rst = r; t.rs = rs; t.rt = rt; t.rd = rd; t.usesRt = u; t.ctrl = c;
        t.valid = v; t.flush = f; t.a = a; t.expPcw = ePcw; t.expValid = eV;
        t.expCtrl = eC; t.expRs = eRs; t.expA = eA; t.expCnt = eCnt;
        return t;
    endfunction

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // A valid load in EX writing a nonzero register that the ID instruction reads.
    function automatic logic modelHazard();
        logic exIsLoad;
        logic reads;
        exIsLoad = mValid && mCtrl[6] && (mRt != 5'd0);
        reads    = (ID_Rs == mRt) || (ID_UsesRt && (ID_Rt == mRt));
        return exIsLoad && ID_Valid && reads;
    endfunction

    task automatic modelClock();
        logic hzNow;
        hzNow = modelHazard();
        if (rst) begin
            mRs = 0; mRt = 0; mRd = 0; mA = 0; mB = 0; mImm = 0;
            mCtrl = 0; mValid = 0; mCnt = 0; mCntSat = 0;
        end else begin
            mRs = ID_Rs; mRt = ID_Rt; mRd = ID_Rd;
            mA = ID_ReadA; mB = ID_ReadB; mImm = ID_Imm;
            if (Flush || hzNow) begin
                mCtrl = 0; mValid = 0;
            end else begin
                mValid = ID_Valid;
                mCtrl  = ID_Valid ? ID_Ctrl : 8'h00;
            end
            if (hzNow && !Flush) begin
                if (mCnt < 65535) mCnt++;
                if (mCntSat < 3) mCntSat++;
            end
        end
    endtask

    // Inputs are already driven; sample the stall enables mid-cycle, then clock once.
    task automatic applyStimulus();
        #2;
        mPcw        = rst || !(modelHazard() && !Flush);
        seenPcw     = PCWrite;
        seenIfid    = IFID_Write;
        seenSatPcw  = sPCWrite;
        seenSatIfid = sIFID_Write;
        @(posedge clk);
        modelClock();
        #1;
    endtask

    task automatic checkOutput();
        checkVal("PCWrite", 64'(seenPcw), 64'(mPcw));
        checkVal("IFID_Write", 64'(seenIfid), 64'(mPcw));
        checkVal("satPCWrite", 64'(seenSatPcw), 64'(mPcw));
        checkVal("satIFID_Write", 64'(seenSatIfid), 64'(mPcw));
        checkVal("IDEX_Regs", 64'({IDEX_Rs, IDEX_Rt, IDEX_Rd}), 64'({mRs, mRt, mRd}));
        checkVal("IDEX_AB", {IDEX_A, IDEX_B}, {mA, mB});
        checkVal("IDEX_Imm", 64'(IDEX_Imm), 64'(mImm));
        checkVal("IDEX_CtrlValid", 64'({IDEX_Ctrl, IDEX_Valid}), 64'({mCtrl, mValid}));
        checkVal("StallCount", 64'(StallCount), 64'(mCnt));
        checkVal("satRegs", 64'({sRs, sRt, sRd}), 64'({mRs, mRt, mRd}));
        checkVal("satAB", {sA, sB}, {mA, mB});
        checkVal("satImm", 64'(sImm), 64'(mImm));
        checkVal("satCtrlValid", 64'({sCtrl, sValid}), 64'({mCtrl, mValid}));
        checkVal("satStallCount", 64'(sStallCount), 64'(mCntSat));
    endtask

    task automatic drive(logic r, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic u,
                         logic [7:0] c, logic v, logic f, logic [31:0] a);
        rst = r; ID_Rs = rs; ID_Rt = rt; ID_Rd = rd; ID_UsesRt = u; ID_Ctrl = c;
        ID_Valid = v; Flush = f; ID_ReadA = a;
        ID_ReadB = a ^ 32'h5a5a_0000; ID_Imm = {16'h0, a[15:0]};
    endtask

    localparam logic [7:0] LW  = 8'hD8;
    localparam logic [7:0] ADD = 8'h86;
    localparam logic [7:0] ADDI = 8'h88;

    initial begin
        drive(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 8'hFF, 1'b1, 1'b0, 32'hDEAD_BEEF);
        mRs = 0; mRt = 0; mRd = 0; mA = 0; mB = 0; mImm = 0;
        mCtrl = 0; mValid = 0; mCnt = 0; mCntSat = 0; mPcw = 1;

        //            rst rs  rt  rd  use ctrl  v  fl  a          pcw  v  ctrl  rs  A         cnt
        table_q.push_back(mk(1, 3, 4, 5, 1, 8'hFF, 1, 0, 32'hDEADBEEF, 1, 0, 8'h00, 0, 32'h0, 0));
        table_q.push_back(mk(1, 3, 4, 5, 1, 8'hFF, 1, 0, 32'hDEADBEEF, 1, 0, 8'h00, 0, 32'h0, 0));
        table_q.push_back(mk(0, 3, 4, 5, 1, ADD,   1, 0, 32'h11,       1, 1, ADD,   3, 32'h11, 0));
        table_q.push_back(mk(0, 1, 2, 0, 0, LW,    1, 0, 32'h22,       1, 1, LW,    1, 32'h22, 0));
        table_q.push_back(mk(0, 2, 3, 4, 1, ADD,   1, 0, 32'h33,       0, 0, 8'h00, 2, 32'h33, 1));
        table_q.push_back(mk(0, 2, 3, 4, 1, ADD,   1, 0, 32'h33,       1, 1, ADD,   2, 32'h33, 1));
        table_q.push_back(mk(0, 1, 7, 0, 0, LW,    1, 0, 32'h44,       1, 1, LW,    1, 32'h44, 1));
        table_q.push_back(mk(0, 5, 7, 0, 0, ADDI,  1, 0, 32'h55,       1, 1, ADDI,  5, 32'h55, 1));
        table_q.push_back(mk(0, 1, 7, 0, 0, LW,    1, 0, 32'h66,       1, 1, LW,    1, 32'h66, 1));
        table_q.push_back(mk(0, 5, 7, 8, 1, ADD,   1, 0, 32'h77,       0, 0, 8'h00, 5, 32'h77, 2));
        table_q.push_back(mk(0, 1, 0, 0, 0, LW,    1, 0, 32'h88,       1, 1, LW,    1, 32'h88, 2));
        table_q.push_back(mk(0, 0, 0, 6, 1, ADD,   1, 0, 32'h99,       1, 1, ADD,   0, 32'h99, 2));
        table_q.push_back(mk(0, 1, 9, 0, 0, LW,    1, 0, 32'hAA,       1, 1, LW,    1, 32'hAA, 2));
        table_q.push_back(mk(0, 9, 3, 4, 0, ADD,   1, 1, 32'hBB,       1, 0, 8'h00, 9, 32'hBB, 2));
        table_q.push_back(mk(0, 3, 3, 4, 0, ADD,   0, 0, 32'hCC,       1, 0, 8'h00, 3, 32'hCC, 2));
        table_q.push_back(mk(0, 1, 4, 0, 0, LW,    1, 0, 32'hDD,       1, 1, LW,    1, 32'hDD, 2));
        table_q.push_back(mk(1, 4, 3, 2, 1, ADD,   1, 0, 32'hEE,       1, 0, 8'h00, 0, 32'h0, 0));

        @(posedge clk);
        #1;
        foreach (table_q[i]) begin
            drive(table_q[i].rst, table_q[i].rs, table_q[i].rt, table_q[i].rd, table_q[i].usesRt,
                  table_q[i].ctrl, table_q[i].valid, table_q[i].flush, table_q[i].a);
            applyStimulus();
            checkVal($sformatf("row%0d.PCWrite", i), 64'(seenPcw), 64'(table_q[i].expPcw));
            checkVal($sformatf("row%0d.IFID_Write", i), 64'(seenIfid), 64'(table_q[i].expPcw));
            checkVal($sformatf("row%0d.IDEX_Valid", i), 64'(IDEX_Valid), 64'(table_q[i].expValid));
            checkVal($sformatf("row%0d.IDEX_Ctrl", i), 64'(IDEX_Ctrl), 64'(table_q[i].expCtrl));
            checkVal($sformatf("row%0d.IDEX_Rs", i), 64'(IDEX_Rs), 64'(table_q[i].expRs));
            checkVal($sformatf("row%0d.IDEX_A", i), 64'(IDEX_A), 64'(table_q[i].expA));
            checkVal($sformatf("row%0d.StallCount", i), 64'(StallCount), 64'(table_q[i].expCnt));
        end

        // Five separate load-use events: the 2-bit counter must stick at 3.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
        applyStimulus();
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 5'd1, 5'd2, 5'd0, 1'b0, LW, 1'b1, 1'b0, 32'h100 + 32'(k));
            applyStimulus();
            drive(1'b0, 5'd2, 5'd3, 5'd4, 1'b1, ADD, 1'b1, 1'b0, 32'h200 + 32'(k));
            applyStimulus();
            checkVal($sformatf("sat%0d.PCWrite", k), 64'(seenSatPcw), 64'(0));
            checkVal($sformatf("sat%0d.satCount", k), 64'(sStallCount), 64'((k < 3) ? k + 1 : 3));
            checkVal($sformatf("sat%0d.fullCount", k), 64'(StallCount), 64'(k + 1));
        end

        // Randomized run with a narrow register range so dependences occur often.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 49) == 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) == 1) ? (8'($urandom) | 8'h40) : 8'($urandom),
                  ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0), $urandom());
            applyStimulus();
            checkOutput();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
